// File: rtl/linear_weight_sequencer.sv
// rtl/linear_weight_sequencer.sv - weight file arbiter and output-major weight streamer (optional abort: LINSEQ_ABORT_EN)
module linear_weight_sequencer #(
   parameter int N_IN   = 40,
   parameter int N_OUT  = 10,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1,
   localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic [ADDR_W-1:0] wf_addr,
   output logic [DATA_W-1:0] wf_din,
   output logic              wf_we,
   input  logic [DATA_W-1:0] wf_dout,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic [IW-1:0]     w_in_idx,
   output logic [OW-1:0]     w_out_idx,
   output logic              w_last_in
`ifdef LINSEQ_ABORT_EN
   ,
   input  logic              abort,
   output logic              aborted
`endif
);

   localparam int TOTAL = N_IN * N_OUT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
   localparam logic [IW-1:0]     LAST_IN   = IW'(N_IN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t state;

   // read-side counters: flat address plus the two index tags, advanced together
   logic [ADDR_W-1:0] rd_addr;
   logic [IW-1:0]     rd_in;
   logic [OW-1:0]     rd_out;

   // one-stage tag pipe matching the weight file's registered read
   logic              in_flight;
   logic [IW-1:0]     tag_in;
   logic [OW-1:0]     tag_out;
   logic              tag_last;

   // two-entry skid FIFO
   logic [DATA_W-1:0] fifo_data [2];
   logic [IW-1:0]     fifo_in   [2];
   logic [OW-1:0]     fifo_out  [2];
   logic              fifo_last [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;

   logic              pop;
   logic              push;
   logic [1:0]        occ;
   logic [1:0]        occ_after;
   logic              issue;
   logic              abort_hit;

   assign pop       = w_valid && w_ready;
   assign push      = in_flight;
   assign occ       = count + {1'b0, in_flight};
   assign occ_after = occ - {1'b0, pop};
   // a read is only issued when its word is guaranteed a FIFO slot on arrival
   assign issue     = (state == S_RUN) && (occ_after < 2'd2);

`ifdef LINSEQ_ABORT_EN
   assign abort_hit = abort && (state != S_IDLE);

   // one-cycle indication that a sweep was cut short by abort
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aborted <= 1'b0;
      end else begin
         aborted <= abort_hit;
      end
   end
`else
   assign abort_hit = 1'b0;
`endif

   // stream head is always the FIFO entry at rd_ptr
   assign w_valid   = (count != 2'd0);
   assign w_data    = fifo_data[rd_ptr];
   assign w_in_idx  = fifo_in[rd_ptr];
   assign w_out_idx = fifo_out[rd_ptr];
   assign w_last_in = fifo_last[rd_ptr];

   // address port ownership: host in IDLE, read counter otherwise
   always_comb begin
      host_ready = (state == S_IDLE);
      if (state == S_IDLE) begin
         wf_addr = host_addr;
         wf_din  = host_wdata;
         wf_we   = host_we;
      end else begin
         wf_addr = rd_addr;
         wf_din  = '0;
         wf_we   = 1'b0;
      end
   end

   // sweep control FSM with read counters, tag pipe and registered busy/done
   always_ff @(posedge clk) begin
      if (!rst_n || abort_hit) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_addr   <= '0;
         rd_in     <= '0;
         rd_out    <= '0;
         in_flight <= 1'b0;
         tag_in    <= '0;
         tag_out   <= '0;
         tag_last  <= 1'b0;
      end else begin
         done      <= 1'b0;
         in_flight <= issue;
         if (issue) begin
            tag_in   <= rd_in;
            tag_out  <= rd_out;
            tag_last <= (rd_in == LAST_IN);
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  busy    <= 1'b1;
                  rd_addr <= '0;
                  rd_in   <= '0;
                  rd_out  <= '0;
               end
            end
            S_RUN: begin
               if (issue) begin
                  if (rd_addr == LAST_ADDR) begin
                     state   <= S_DRAIN;
                     rd_addr <= '0;
                     rd_in   <= '0;
                     rd_out  <= '0;
                  end else begin
                     rd_addr <= rd_addr + ADDR_W'(1);
                     if (rd_in == LAST_IN) begin
                        rd_in  <= '0;
                        rd_out <= rd_out + OW'(1);
                     end else begin
                        rd_in  <= rd_in + IW'(1);
                     end
                  end
               end
            end
            S_DRAIN: begin
               // finish on the edge that hands off the final beat
               if (occ_after == 2'd0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // skid FIFO: capture returning read words, release on handshake
   always_ff @(posedge clk) begin
      if (!rst_n || abort_hit) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_in[i]   <= '0;
            fifo_out[i]  <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= wf_dout;
            fifo_in[wr_ptr]   <= tag_in;
            fifo_out[wr_ptr]  <= tag_out;
            fifo_last[wr_ptr] <= tag_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_linear_weight_sequencer.sv
// tb/tb_linear_weight_sequencer.sv - directed self-checking bench for linear_weight_sequencer
module tb_linear_weight_sequencer;

   localparam int N_IN   = 40;
   localparam int N_OUT  = 10;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int TOTAL  = N_IN * N_OUT;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              busy;
   logic              done;
   logic              host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic              host_ready;
   logic [ADDR_W-1:0] wf_addr;
   logic [DATA_W-1:0] wf_din;
   logic              wf_we;
   logic [DATA_W-1:0] wf_dout = '0;
   logic              w_valid;
   logic              w_ready = 1'b0;
   logic [DATA_W-1:0] w_data;
   logic [5:0]        w_in_idx;
   logic [3:0]        w_out_idx;
   logic              w_last_in;
`ifdef LINSEQ_ABORT_EN
   logic              abort = 1'b0;
   logic              aborted;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [DATA_W-1:0] model [0:TOTAL-1];
   logic [DATA_W-1:0] ram   [0:(1<<ADDR_W)-1];

   linear_weight_sequencer #(
      .N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ready(host_ready), .wf_addr(wf_addr), .wf_din(wf_din), .wf_we(wf_we),
      .wf_dout(wf_dout), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_in_idx(w_in_idx), .w_out_idx(w_out_idx), .w_last_in(w_last_in)
`ifdef LINSEQ_ABORT_EN
      , .abort(abort), .aborted(aborted)
`endif
   );

   always #5 clk = ~clk;

   // weight register file: synchronous write, registered read
   always @(posedge clk) begin
      if (wf_we) ram[wf_addr] <= wf_din;
      wf_dout <= ram[wf_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic host_write(input int a, input logic [DATA_W-1:0] d);
      host_we    = 1'b1;
      host_addr  = ADDR_W'(a);
      host_wdata = d;
      @(negedge clk);
      host_we    = 1'b0;
   endtask

   // cut: 0 none, 1 reset at cut_at beats, 2 abort at cut_at beats
   task automatic sweep(input bit rnd, input bit poke_start, input bit poke_host,
                        input int cut, input int cut_at, input bit start_wr);
      int n = 0;
      int cyc = 0;
      int first_cyc = -1;
      int last_cyc = -1;
      int done_cyc = -1;
      int extra_done = 0;
      bit poked_s = 0;
      bit poked_h = 0;
      logic [10:0] exp_tag;
      start = 1'b1;
      if (start_wr) begin
         host_we    = 1'b1;
         host_addr  = ADDR_W'(7);
         host_wdata = 32'h7777_0007;
         model[7]   = 32'h7777_0007;
      end
      @(negedge clk);
      start   = 1'b0;
      host_we = 1'b0;
      check("busy_run", busy, 1);
      check("host_ready_run", host_ready, 0);
      while (cyc < 3000) begin
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (cut == 1 && n == cut_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            check("rst_w_valid", w_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            rst_n = 1'b1;
            return;
         end
`ifdef LINSEQ_ABORT_EN
         if (cut == 2 && n == cut_at) begin
            w_ready = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("abort_pre_valid", w_valid, 1);
            check("abort_pre_data", w_data, model[cut_at]);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_w_valid", w_valid, 0);
            check("abort_pulse", aborted, 1);
            check("abort_done", done, 0);
            check("abort_host_ready", host_ready, 1);
            check("abort_busy", busy, 0);
            @(negedge clk);
            check("abort_pulse_end", aborted, 0);
            check("abort_no_done", done, 0);
            return;
         end
`endif
         if (w_valid) begin
            if (n < TOTAL) begin
               exp_tag = {(n % N_IN) == N_IN - 1, 4'(n / N_IN), 6'(n % N_IN)};
               check($sformatf("beat%0d_data", n), w_data, model[n]);
               check($sformatf("beat%0d_tag", n), {w_last_in, w_out_idx, w_in_idx}, exp_tag);
            end else begin
               check("extra_beat", 1, 0);
            end
         end
         start = (poke_start && n == 150 && !poked_s);
         if (start) poked_s = 1;
         if (poke_host && n == 50 && !poked_h) begin
            poked_h    = 1;
            host_we    = 1'b1;
            host_addr  = ADDR_W'(5);
            host_wdata = 32'hDEAD_BEEF;
            #1;
            check("poke_host_ready", host_ready, 0);
            check("poke_wf_we", wf_we, 0);
         end
         w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (w_valid && w_ready) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      w_ready = 1'b0;
      check("beat_count", n, TOTAL);
      check("done_after_last", done_cyc - last_cyc, 1);
      check("busy_at_done", busy, 0);
      check("host_ready_at_done", host_ready, 1);
      if (!rnd) begin
         check("first_beat_latency", first_cyc, 2);
         check("back_to_back", last_cyc - first_cyc, TOTAL - 1);
      end
      if (poke_host) begin
         check("held_write_we", wf_we, 1);
         check("held_write_addr", wf_addr, 5);
         model[5] = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      host_we = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (done) extra_done++;
         @(negedge clk);
      end
      check("single_done", extra_done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_w_valid", w_valid, 0);
      check("reset_w_data", w_data, 0);
      check("reset_last", w_last_in, 0);
      check("reset_idx", {w_out_idx, w_in_idx}, 0);
      check("reset_host_ready", host_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < TOTAL; i++) begin
         model[i] = 32'h1000_0000 + 32'(i);
         host_write(i, model[i]);
      end

      sweep(0, 0, 0, 0, 0, 0);
      sweep(1, 0, 0, 0, 0, 0);
      sweep(0, 0, 1, 0, 0, 0);
      sweep(0, 0, 0, 0, 0, 0);
      sweep(1, 1, 0, 0, 0, 0);
      sweep(0, 0, 0, 1, 200, 0);
      sweep(0, 0, 0, 0, 0, 1);
`ifdef LINSEQ_ABORT_EN
      sweep(0, 0, 0, 2, 100, 0);
      sweep(0, 0, 0, 0, 0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
